dmem_bank: RTL and testbench
============================

DMEM_BANK -- requirements
Module: dmem_bank

Interface
REQ-001 Param ADDR_WIDTH, 13, byte-address width; depth = 2**(ADDR_WIDTH-2) 32-bit words.
REQ-002 Param READ_LATENCY, 1, request-accept to response cycles; legal values 1 or 2.
REQ-003 Param CLEAR_ON_RESET, 1, when 1 zero-fill all words after reset release.
REQ-004 Param INIT_FILE, "", hex image loaded at elaboration when non-empty.
REQ-005 CLK  in  1  single clock; all state updates on rising edge.
REQ-006 RST  in  1  reset, asynchronous, active-high.
REQ-007 REQ_VALID  in  1  request present.
REQ-008 REQ_READY  out  1  request accepted when REQ_VALID and REQ_READY both high at an edge.
REQ-009 REQ_WE  in  1  1 = store, 0 = load.
REQ-010 REQ_ADDR  in  ADDR_WIDTH  byte address.
REQ-011 REQ_SIZE  in  2  0 byte, 1 half, 2 word, 3 reserved.
REQ-012 REQ_UNSIGNED  in  1  load zero-extends when 1, sign-extends when 0.
REQ-013 REQ_WDATA  in  32  store data, right-justified.
REQ-014 RSP_VALID  out  1  one-cycle response pulse.
REQ-015 RSP_RDATA  out  32  formatted load data; 0 for stores and errors.
REQ-016 RSP_ERR  out  1  misaligned or reserved-size request.
REQ-017 BUSY  out  1  zero-fill in progress.

Function
REQ-018 FSM states CLEAR, IDLE; REQ_READY = 1 only in IDLE and never depends on REQ_VALID.
REQ-019 On reset release: CLEAR if CLEAR_ON_RESET = 1, else IDLE.
REQ-020 CLEAR: counter 0..depth-1 writes 0 to one word per cycle; after last word -> IDLE; BUSY = 1 exactly depth cycles.
REQ-021 Every accepted request yields exactly one RSP_VALID pulse, in order, exactly READ_LATENCY cycles after acceptance; one request per cycle sustained.
REQ-022 Misaligned = half with ADDR[0] = 1, or word with ADDR[1:0] != 0; it and SIZE = 3 give RSP_ERR = 1, RSP_RDATA = 0, no memory write.
REQ-023 Store: byte lanes from SIZE and ADDR[1:0]; WDATA byte/half replicated into selected lane(s); other lanes unchanged.
REQ-024 Load: selected lane(s) shifted to bit 0, extended per REQ_UNSIGNED to 32 bits.
REQ-025 Load immediately after store to same word returns post-store data (no stale read).
REQ-026 Word index = ADDR[ADDR_WIDTH-1:2]; no wrap or aliasing beyond depth.

Reset
REQ-027 While RST high: RSP_VALID 0, RSP_RDATA 0, RSP_ERR 0, REQ_READY 0, BUSY 0, clear counter 0, in-flight responses discarded.
REQ-028 Memory array not reset; RST asserted mid-CLEAR aborts and restarts the fill from word 0 after release.

Structure
REQ-029 Package dmem_pkg holds SIZE encodings (SZ_B, SZ_H, SZ_W), FSM state type, word width 32.
REQ-030 Sub-module dmem_array: plain word-wide RAM with 4 byte-write enables, 1-cycle registered read; second latency stage in dmem_bank.

Verification
REQ-031 Reset release, CLEAR_ON_RESET = 1, ADDR_WIDTH = 6 -> BUSY high exactly 16 cycles, REQ_READY 0 throughout; load word 0x3C afterwards -> 0x00000000.
REQ-032 Store word 0x11223344 @0x8, load byte @0xB signed -> 0x00000011; load half @0xA unsigned -> 0x00001122.
REQ-033 Store byte 0x80 @0x9 over 0x11223344, load word @0x8 -> 0x11228044; load byte @0x9 signed -> 0xFFFFFF80.
REQ-034 Load half @0x5 -> RSP_ERR 1, RSP_RDATA 0; store word @0x6 -> RSP_ERR 1, memory unchanged.
REQ-035 READ_LATENCY = 2, back-to-back store 0xCAFEF00D @0x10 then load @0x10 -> load RSP_VALID 2 cycles after its acceptance, data 0xCAFEF00D, responses in order.
REQ-036 RST pulsed at CLEAR cycle 5 -> BUSY 0 during reset, then full depth-cycle fill, all words read 0.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory bank: access sizes, FSM states, word geometry
// and the alignment check used by the request decoder.
package dmem_pkg;

   localparam int WORD_W = 32;
   localparam int BE_W   = WORD_W / 8;

   localparam logic [1:0] SZ_B   = 2'd0;
   localparam logic [1:0] SZ_H   = 2'd1;
   localparam logic [1:0] SZ_W   = 2'd2;
   localparam logic [1:0] SZ_RSV = 2'd3;

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_IDLE  = 1'b1
   } state_e;

   // Reserved size or a half/word access that straddles its natural boundary.
   function automatic logic req_bad(input logic [1:0] size, input logic [1:0] lane);
      logic bad;
      case (size)
         SZ_B:    bad = 1'b0;
         SZ_H:    bad = lane[0];
         SZ_W:    bad = (lane != 2'b00);
         default: bad = 1'b1;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-wide single-port RAM with per-byte write enables and a registered read port.
// Read returns the word as it was before any write on the same edge.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int    IDX_W     = 11,
  parameter string INIT_FILE = ""
) (
  input  logic              clk,
  input  logic [BE_W-1:0]   be,
  input  logic [IDX_W-1:0]  addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata_q
);

  localparam int DEPTH = 1 << IDX_W;

  logic [WORD_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    for (int b = 0; b < BE_W; b++) begin
      if (be[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
    end
    rdata_q <= mem[addr];
  end

endmodule

// File: rtl/dmem_bank.sv
// Data-memory bank: byte/half/word loads and stores with alignment checking,
// post-reset zero-fill, and a fixed 1- or 2-cycle in-order response pipeline.
module dmem_bank
   import dmem_pkg::*;
#(
   parameter int    ADDR_WIDTH     = 13,
   parameter int    READ_LATENCY   = 1,
   parameter bit    CLEAR_ON_RESET = 1'b1,
   parameter string INIT_FILE      = ""
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  REQ_VALID,
   output logic                  REQ_READY,
   input  logic                  REQ_WE,
   input  logic [ADDR_WIDTH-1:0] REQ_ADDR,
   input  logic [1:0]            REQ_SIZE,
   input  logic                  REQ_UNSIGNED,
   input  logic [WORD_W-1:0]     REQ_WDATA,
   output logic                  RSP_VALID,
   output logic [WORD_W-1:0]     RSP_RDATA,
   output logic                  RSP_ERR,
   output logic                  BUSY
);

   localparam int IDX_W = ADDR_WIDTH - 2;
   localparam int DEPTH = 1 << IDX_W;

   function automatic logic [BE_W-1:0] store_be(input logic [1:0] size, input logic [1:0] lane);
      logic [BE_W-1:0] be;
      case (size)
         SZ_B:    be = 4'b0001 << lane;
         SZ_H:    be = lane[1] ? 4'b1100 : 4'b0011;
         default: be = 4'b1111;
      endcase
      return be;
   endfunction

   function automatic logic [WORD_W-1:0] store_data(input logic [1:0] size, input logic [WORD_W-1:0] wd);
      logic [WORD_W-1:0] d;
      case (size)
         SZ_B:    d = {4{wd[7:0]}};
         SZ_H:    d = {2{wd[15:0]}};
         default: d = wd;
      endcase
      return d;
   endfunction

   function automatic logic [WORD_W-1:0] load_fmt(input logic [WORD_W-1:0] word, input logic [1:0] size,
                                                  input logic [1:0] lane, input logic uns);
      logic [WORD_W-1:0] sh;
      logic [7:0]        b;
      logic [15:0]       h;
      logic [WORD_W-1:0] res;
      sh = word >> {lane, 3'b000};
      b  = sh[7:0];
      h  = lane[1] ? word[31:16] : word[15:0];
      case (size)
         SZ_B:    res = uns ? {24'b0, b} : {{24{b[7]}}, b};
         SZ_H:    res = uns ? {16'b0, h} : {{16{h[15]}}, h};
         default: res = word;
      endcase
      return res;
   endfunction

   state_e             state_q, state_d;
   logic [IDX_W-1:0]   clr_cnt_q, clr_cnt_d;
   logic               clr_we;

   logic               acc;
   logic               req_err;
   logic [BE_W-1:0]    arr_be;
   logic [IDX_W-1:0]   arr_addr;
   logic [WORD_W-1:0]  arr_wdata;
   logic [WORD_W-1:0]  arr_rdata;

   logic               vld_p1_q, vld_p1_d;
   logic               we_p1_q, we_p1_d;
   logic               err_p1_q, err_p1_d;
   logic [1:0]         size_p1_q, size_p1_d;
   logic [1:0]         lane_p1_q, lane_p1_d;
   logic               uns_p1_q, uns_p1_d;
   logic [WORD_W-1:0]  rdata_p1;
   logic               rsp_err_p1;

   // Outputs are gated by RST so the bank looks idle for the whole reset pulse.
   always_comb begin
      state_d   = state_q;
      clr_cnt_d = clr_cnt_q;
      clr_we    = 1'b0;
      case (state_q)
         ST_CLEAR: begin
            clr_we    = !RST;
            clr_cnt_d = clr_cnt_q + 1'b1;
            if (clr_cnt_q == IDX_W'(DEPTH - 1)) begin
               state_d   = ST_IDLE;
               clr_cnt_d = '0;
            end
         end
         default: ;
      endcase
      REQ_READY = !RST && (state_q == ST_IDLE);
      BUSY      = !RST && (state_q == ST_CLEAR);
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q   <= CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;
         clr_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         clr_cnt_q <= clr_cnt_d;
      end
   end

   // Stage p0: decode the request and drive the array port.
   always_comb begin
      acc       = REQ_VALID && REQ_READY;
      req_err   = req_bad(REQ_SIZE, REQ_ADDR[1:0]);
      arr_be    = '0;
      arr_addr  = REQ_ADDR[ADDR_WIDTH-1:2];
      arr_wdata = store_data(REQ_SIZE, REQ_WDATA);
      if (clr_we) begin
         arr_be    = '1;
         arr_addr  = clr_cnt_q;
         arr_wdata = '0;
      end else if (acc && REQ_WE && !req_err) begin
         arr_be    = store_be(REQ_SIZE, REQ_ADDR[1:0]);
      end
      vld_p1_d  = acc;
      we_p1_d   = REQ_WE;
      err_p1_d  = req_err;
      size_p1_d = REQ_SIZE;
      lane_p1_d = REQ_ADDR[1:0];
      uns_p1_d  = REQ_UNSIGNED;
   end

   dmem_array #(
      .IDX_W     (IDX_W),
      .INIT_FILE (INIT_FILE)
   ) u_array (
      .clk     (CLK),
      .be      (arr_be),
      .addr    (arr_addr),
      .wdata   (arr_wdata),
      .rdata_q (arr_rdata)
   );

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) vld_p1_q <= 1'b0;
      else     vld_p1_q <= vld_p1_d;
   end

   always_ff @(posedge CLK) begin
      we_p1_q   <= we_p1_d;
      err_p1_q  <= err_p1_d;
      size_p1_q <= size_p1_d;
      lane_p1_q <= lane_p1_d;
      uns_p1_q  <= uns_p1_d;
   end

   // Stage p1: format the array word; stores and errors respond with zero data.
   always_comb begin
      rdata_p1   = '0;
      rsp_err_p1 = vld_p1_q && err_p1_q;
      if (vld_p1_q && !we_p1_q && !err_p1_q)
         rdata_p1 = load_fmt(arr_rdata, size_p1_q, lane_p1_q, uns_p1_q);
   end

   generate
      if (READ_LATENCY >= 2) begin : g_lat2
         logic              vld_p2_q, vld_p2_d;
         logic              err_p2_q, err_p2_d;
         logic [WORD_W-1:0] rdata_p2_q, rdata_p2_d;

         always_comb begin
            vld_p2_d   = vld_p1_q;
            err_p2_d   = rsp_err_p1;
            rdata_p2_d = rdata_p1;
         end

         // Stage p2: extra output register for the two-cycle latency build.
         always_ff @(posedge CLK or posedge RST) begin
            if (RST) begin
               vld_p2_q   <= 1'b0;
               err_p2_q   <= 1'b0;
               rdata_p2_q <= '0;
            end else begin
               vld_p2_q   <= vld_p2_d;
               err_p2_q   <= err_p2_d;
               rdata_p2_q <= rdata_p2_d;
            end
         end

         assign RSP_VALID = vld_p2_q;
         assign RSP_ERR   = err_p2_q;
         assign RSP_RDATA = rdata_p2_q;
      end else begin : g_lat1
         assign RSP_VALID = vld_p1_q;
         assign RSP_ERR   = rsp_err_p1;
         assign RSP_RDATA = rdata_p1;
      end
   endgenerate

endmodule

// File: tb/tb_dmem_bank.sv
// Directed bench: two banks (latency 1 and 2, 16 words each) share one request stream.
module tb_dmem_bank;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_we;
   logic [5:0]  req_addr;
   logic [1:0]  req_size;
   logic        req_uns;
   logic [31:0] req_wdata;

   logic        a_ready, a_vld, a_err, a_busy;
   logic [31:0] a_data;
   logic        b_ready, b_vld, b_err, b_busy;
   logic [31:0] b_data;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   dmem_bank #(.ADDR_WIDTH(6), .READ_LATENCY(1), .CLEAR_ON_RESET(1'b1), .INIT_FILE("")) u_a (
      .CLK(clk), .RST(rst), .REQ_VALID(req_valid), .REQ_READY(a_ready), .REQ_WE(req_we),
      .REQ_ADDR(req_addr), .REQ_SIZE(req_size), .REQ_UNSIGNED(req_uns), .REQ_WDATA(req_wdata),
      .RSP_VALID(a_vld), .RSP_RDATA(a_data), .RSP_ERR(a_err), .BUSY(a_busy)
   );

   dmem_bank #(.ADDR_WIDTH(6), .READ_LATENCY(2), .CLEAR_ON_RESET(1'b1), .INIT_FILE("")) u_b (
      .CLK(clk), .RST(rst), .REQ_VALID(req_valid), .REQ_READY(b_ready), .REQ_WE(req_we),
      .REQ_ADDR(req_addr), .REQ_SIZE(req_size), .REQ_UNSIGNED(req_uns), .REQ_WDATA(req_wdata),
      .RSP_VALID(b_vld), .RSP_RDATA(b_data), .RSP_ERR(b_err), .BUSY(b_busy)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One request; bank A answers one cycle after acceptance, bank B two cycles after.
   task automatic xact(input string tag, input logic we, input logic [5:0] addr, input logic [1:0] size,
                       input logic uns, input logic [31:0] wd, input logic [31:0] exp_d, input logic exp_e);
      @(negedge clk);
      req_valid = 1'b1; req_we = we; req_addr = addr; req_size = size; req_uns = uns; req_wdata = wd;
      #1;
      chk({tag, "_rdy"}, {30'b0, a_ready, b_ready}, 32'h3);
      @(posedge clk); #1;
      req_valid = 1'b0;
      chk({tag, "_a_vld"}, {31'b0, a_vld}, 32'h1);
      chk({tag, "_a_data"}, a_data, exp_d);
      chk({tag, "_a_err"}, {31'b0, a_err}, {31'b0, exp_e});
      chk({tag, "_b_early"}, {31'b0, b_vld}, 32'h0);
      @(posedge clk); #1;
      chk({tag, "_b_vld"}, {31'b0, b_vld}, 32'h1);
      chk({tag, "_b_data"}, b_data, exp_d);
      chk({tag, "_b_err"}, {31'b0, b_err}, {31'b0, exp_e});
      chk({tag, "_a_once"}, {31'b0, a_vld}, 32'h0);
   endtask

   // Release happens at a falling edge; count falling-edge samples with BUSY high.
   task automatic count_fill(input string tag);
      int busy_a = 0;
      int busy_b = 0;
      int rdy_during = 0;
      for (int i = 0; i < 30; i++) begin
         #1;
         if (a_busy) busy_a++;
         if (b_busy) busy_b++;
         if ((a_busy && a_ready) || (b_busy && b_ready)) rdy_during++;
         @(negedge clk);
      end
      chk({tag, "_busy_a"}, busy_a, 32'd16);
      chk({tag, "_busy_b"}, busy_b, 32'd16);
      chk({tag, "_rdy_busy"}, rdy_during, 32'd0);
      chk({tag, "_rdy_after"}, {30'b0, a_ready, b_ready}, 32'h3);
   endtask

   initial begin
      rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
      req_size = 2'd0; req_uns = 1'b0; req_wdata = '0;

      repeat (2) @(negedge clk);
      #1;
      chk("rst_outs_a", {a_vld, a_err, a_ready, a_busy, a_data}, 36'h0);
      chk("rst_outs_b", {b_vld, b_err, b_ready, b_busy, b_data}, 36'h0);

      @(negedge clk);
      rst = 1'b0;
      count_fill("fill1");
      xact("ld_3c", 1'b0, 6'h3C, 2'd2, 1'b0, 32'h0, 32'h0000_0000, 1'b0);

      xact("st_w8",   1'b1, 6'h08, 2'd2, 1'b0, 32'h1122_3344, 32'h0, 1'b0);
      xact("ld_bB_s", 1'b0, 6'h0B, 2'd0, 1'b0, 32'h0, 32'h0000_0011, 1'b0);
      xact("ld_hA_u", 1'b0, 6'h0A, 2'd1, 1'b1, 32'h0, 32'h0000_1122, 1'b0);

      xact("st_b9",   1'b1, 6'h09, 2'd0, 1'b0, 32'h0000_0080, 32'h0, 1'b0);
      xact("ld_w8",   1'b0, 6'h08, 2'd2, 1'b0, 32'h0, 32'h1122_8044, 1'b0);
      xact("ld_b9_s", 1'b0, 6'h09, 2'd0, 1'b0, 32'h0, 32'hFFFF_FF80, 1'b0);
      xact("ld_b9_u", 1'b0, 6'h09, 2'd0, 1'b1, 32'h0, 32'h0000_0080, 1'b0);

      xact("st_hE",   1'b1, 6'h0E, 2'd1, 1'b0, 32'h0000_8001, 32'h0, 1'b0);
      xact("ld_wC",   1'b0, 6'h0C, 2'd2, 1'b0, 32'h0, 32'h8001_0000, 1'b0);
      xact("ld_hE_s", 1'b0, 6'h0E, 2'd1, 1'b0, 32'h0, 32'hFFFF_8001, 1'b0);

      xact("st_w4",   1'b1, 6'h04, 2'd2, 1'b0, 32'hA5A5_A5A5, 32'h0, 1'b0);
      xact("ld_h5",   1'b0, 6'h05, 2'd1, 1'b0, 32'h0, 32'h0, 1'b1);
      xact("st_w6",   1'b1, 6'h06, 2'd2, 1'b0, 32'hDEAD_BEEF, 32'h0, 1'b1);
      xact("ld_w4",   1'b0, 6'h04, 2'd2, 1'b0, 32'h0, 32'hA5A5_A5A5, 1'b0);
      xact("ld_rsv",  1'b0, 6'h00, 2'd3, 1'b0, 32'h0, 32'h0, 1'b1);

      // Back-to-back store then load of the same word.
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_addr = 6'h10; req_size = 2'd2; req_uns = 1'b0;
      req_wdata = 32'hCAFE_F00D;
      @(posedge clk); #1;
      req_we = 1'b0; req_wdata = '0;
      chk("b2b_a_st_vld", {31'b0, a_vld}, 32'h1);
      chk("b2b_a_st_data", a_data, 32'h0);
      chk("b2b_b_st_early", {31'b0, b_vld}, 32'h0);
      @(posedge clk); #1;
      req_valid = 1'b0;
      chk("b2b_a_ld_vld", {31'b0, a_vld}, 32'h1);
      chk("b2b_a_ld_data", a_data, 32'hCAFE_F00D);
      chk("b2b_b_st_vld", {31'b0, b_vld}, 32'h1);
      chk("b2b_b_st_data", b_data, 32'h0);
      @(posedge clk); #1;
      chk("b2b_b_ld_vld", {31'b0, b_vld}, 32'h1);
      chk("b2b_b_ld_data", b_data, 32'hCAFE_F00D);
      chk("b2b_a_idle", {31'b0, a_vld}, 32'h0);
      @(posedge clk); #1;
      chk("b2b_b_idle", {31'b0, b_vld}, 32'h0);

      // Make every word nonzero so the refill is visible.
      for (int i = 0; i < 16; i++)
         xact("fill_st", 1'b1, 6'(i * 4), 2'd2, 1'b0, 32'h0101_0101 * (i + 1), 32'h0, 1'b0);

      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      repeat (5) @(negedge clk);
      rst = 1'b1;
      #1;
      chk("mid_rst_busy", {30'b0, a_busy, b_busy}, 32'h0);
      chk("mid_rst_rdy", {30'b0, a_ready, b_ready}, 32'h0);
      chk("mid_rst_vld", {30'b0, a_vld, b_vld}, 32'h0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      count_fill("fill2");

      for (int i = 0; i < 16; i++)
         xact("zero_ld", 1'b0, 6'(i * 4), 2'd2, 1'b0, 32'h0, 32'h0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
